cpu_run_ctrl: RTL

- Run/halt controller facing the CPU core; it is the counterpart of the core's clk/rst/hlt interface.
- Sequences the core's reset, counts execution cycles, detects the core's hlt, and reports the final cycle count.
- Optional watchdog aborts runs that never halt.
- Sits between the top-level system reset/start logic and the CPU instance.

---
 rtl/cpu_run_pkg.sv | 16 +
 rtl/sat_counter.sv | 27 ++
 rtl/cpu_run_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and default constants for the CPU run/halt controller.
package cpu_run_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RESET,
      RUN,
      HALTED,
      TIMEOUT
   } run_state_t;

   localparam int CPU_RUN_RST_CYCLES = 2;
   localparam int CPU_RUN_CNT_W      = 8;
   localparam int CPU_RUN_WDOG_LIMIT = 200;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-value compare.
module sat_counter #(
   parameter int         W    = 8,
   parameter logic [W-1:0] TERM = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q,
   output logic         at_term
);

   // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en && (q != '1)) begin
         q <= q + W'(1);
      end
   end

   assign at_term = (q == TERM);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt controller for the CPU core: reset sequencing, cycle counting, halt detection.
// Define CPU_RUN_WDOG_EN to enable the watchdog that aborts runs reaching WDOG_LIMIT cycles.
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int               RST_CYCLES = CPU_RUN_RST_CYCLES,
   parameter int               CNT_W      = CPU_RUN_CNT_W,
   parameter logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(CPU_RUN_WDOG_LIMIT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             hlt,
   output logic             core_rst,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [3:0]       RST_TERM  = 4'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] WDOG_TERM = WDOG_LIMIT - CNT_W'(1);

   run_state_t state;
   logic       start_ok;
   logic       rst_done;
   logic       cyc_term;
   logic [3:0] rst_dly;

   // start only takes effect where a fresh run may begin.
   assign start_ok = start && (state inside {IDLE, HALTED, TIMEOUT});

   sat_counter #(.W(4), .TERM(RST_TERM)) u_rst_dly (
      .clk     (clk),
      .rst     (rst),
      .clr     (start_ok),
      .en      (state == RESET),
      .q       (rst_dly),
      .at_term (rst_done)
   );

   sat_counter #(.W(CNT_W), .TERM(WDOG_TERM)) u_cycles (
      .clk     (clk),
      .rst     (rst),
      .clr     (start_ok),
      .en      ((state == RUN) && !hlt),
      .q       (cycle_count),
      .at_term (cyc_term)
   );

`ifdef CPU_RUN_WDOG_EN
   logic timeout_q;
   logic unused_sig;
   assign timeout    = timeout_q;
   assign unused_sig = ^rst_dly;
`else
   logic unused_sig;
   assign timeout    = 1'b0;
   assign unused_sig = ^{rst_dly, cyc_term};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         core_rst  <= 1'b1;
         running   <= 1'b0;
         done      <= 1'b0;
`ifdef CPU_RUN_WDOG_EN
         timeout_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) state <= RESET;
            end
            RESET: begin
               if (rst_done) begin
                  state    <= RUN;
                  core_rst <= 1'b0;
                  running  <= 1'b1;
               end
            end
            RUN: begin
               // hlt outranks both start and the watchdog; core_rst stays low to hold the halt.
               if (hlt) begin
                  state   <= HALTED;
                  running <= 1'b0;
                  done    <= 1'b1;
`ifdef CPU_RUN_WDOG_EN
               end else if (cyc_term) begin
                  state     <= TIMEOUT;
                  running   <= 1'b0;
                  core_rst  <= 1'b1;
                  timeout_q <= 1'b1;
`endif
               end
            end
            HALTED: begin
               if (start) begin
                  state    <= RESET;
                  done     <= 1'b0;
                  core_rst <= 1'b1;
               end
            end
`ifdef CPU_RUN_WDOG_EN
            TIMEOUT: begin
               if (start) begin
                  state     <= RESET;
                  timeout_q <= 1'b0;
               end
            end
`endif
            default: begin
               state    <= IDLE;
               core_rst <= 1'b1;
               running  <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule
